// File: rtl/alu_seq.sv
// Sequential saturating ALU: single-cycle ADD/SUB/NOT/PASS, shift-add MUL, double-dabble DGT/DST.
// Optional out_sat/out_zero flag outputs are enabled by defining ALU_SEQ_FLAGS_EN.
module alu_seq #(
    parameter int WIDTH  = 11,
    parameter int DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              inst,
    input  logic signed [WIDTH-1:0] arg1,
    input  logic signed [WIDTH-1:0] arg2,
    input  logic signed [WIDTH-1:0] acc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic                    out_sat,
    output logic                    out_zero
`endif
);

    localparam int SAT_MAX = 10**DIGITS - 1;
    localparam int RW = 2*WIDTH + 1;
    localparam int BW = 4*DIGITS;
    localparam int CW = $clog2(WIDTH);

    localparam logic signed [RW-1:0] SMAX_R = RW'(SAT_MAX);
    localparam logic [2*WIDTH-1:0]   SMAX_P = (2*WIDTH)'(SAT_MAX);
    localparam logic [WIDTH-1:0]     SMAX_W = WIDTH'(SAT_MAX);

    localparam logic [3:0] OP_ADD = 4'd5;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;
    localparam logic [3:0] OP_NOT = 4'd8;
    localparam logic [3:0] OP_DGT = 4'd10;
    localparam logic [3:0] OP_DST = 4'd11;

    typedef enum logic [1:0] {IDLE, MUL, CONV, DONE} state_t;

    state_t                  state_q;
    logic [3:0]              op_q;
    logic signed [WIDTH-1:0] a1_q, a2_q, acc_q, out_q;
    logic [2*WIDTH-1:0]      mcand_q, prod_q;
    logic [WIDTH-1:0]        mplier_q, bin_q;
    logic [BW-1:0]           bcd_q;
    logic [CW-1:0]           cnt_q;
    logic                    out_valid_q;

    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
    endfunction

    function automatic logic [WIDTH:0] clamp(input logic signed [RW-1:0] v);
        if (v > SMAX_R)
            return {1'b1, WIDTH'(SAT_MAX)};
        else if (v < -SMAX_R)
            return {1'b1, WIDTH'(-SAT_MAX)};
        return {1'b0, v[WIDTH-1:0]};
    endfunction

    assign in_ready  = (state_q == IDLE) && !out_valid_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;

    logic is_mul, is_conv, accept, last;
    logic [WIDTH-1:0] acc_mag, acc_clip;

    assign is_mul   = (inst == OP_MUL);
    assign is_conv  = (inst == OP_DGT) || (inst == OP_DST);
    assign accept   = in_valid && in_ready;
    assign last     = (cnt_q == CW'(WIDTH-1));
    assign acc_mag  = mag(acc);
    assign acc_clip = (acc_mag > SMAX_W) ? SMAX_W : acc_mag;

    // Single-cycle ops evaluated straight from the request inputs.
    logic signed [RW-1:0]    fx;
    logic signed [WIDTH-1:0] f_res;
    logic                    f_sat;

    always_comb begin
        fx = '0;
        case (inst)
            OP_ADD:  fx = RW'(acc) + RW'(arg1);
            OP_SUB:  fx = RW'(acc) - RW'(arg1);
            OP_NOT:  fx = (acc == '0) ? RW'(100) : '0;
            default: fx = RW'(acc);
        endcase
        {f_sat, f_res} = clamp(fx);
        if (!(inst inside {OP_ADD, OP_SUB, OP_NOT})) begin
            f_res = acc;
            f_sat = 1'b0;
        end
    end

    // Final-cycle results of the iterative ops.
    logic [2*WIDTH-1:0]      pnx, pmag;
    logic [WIDTH-1:0]        mag_w, dmag, amag_q;
    logic signed [WIDTH-1:0] m_res, c_res, s_res;
    logic                    m_sat, c_sat, s_sat, idx_ok, neg;
    logic [BW-1:0]           bcd_adj, bcd_nx, bcd_mod;
    logic [3:0]              d, dgt, dval;

    always_comb begin
        pnx    = prod_q + (mplier_q[0] ? mcand_q : '0);
        m_sat  = (pnx > SMAX_P);
        pmag   = m_sat ? SMAX_P : pnx;
        mag_w  = pmag[WIDTH-1:0];
        m_res  = (acc_q[WIDTH-1] ^ a1_q[WIDTH-1]) ? -$signed(mag_w)
                                                  : $signed(mag_w);

        bcd_adj = '0;
        d       = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d = bcd_q[4*i +: 4];
            bcd_adj[4*i +: 4] = (d >= 4'd5) ? d + 4'd3 : d;
        end
        bcd_nx = {bcd_adj[BW-2:0], bin_q[WIDTH-1]};

        idx_ok = !a1_q[WIDTH-1] && ($unsigned(a1_q) < WIDTH'(DIGITS));
        if (a2_q[WIDTH-1])
            dval = 4'd0;
        else if ($unsigned(a2_q) > WIDTH'(9))
            dval = 4'd9;
        else
            dval = a2_q[3:0];

        dgt     = '0;
        bcd_mod = bcd_nx;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_ok && ($unsigned(a1_q) == WIDTH'(i))) begin
                dgt = bcd_nx[4*i +: 4];
                bcd_mod[4*i +: 4] = dval;
            end
        end

        dmag = '0;
        for (int i = DIGITS-1; i >= 0; i--)
            dmag = dmag * WIDTH'(10) + WIDTH'(bcd_mod[4*i +: 4]);

        neg    = acc_q[WIDTH-1];
        amag_q = mag(acc_q);
        if (op_q == OP_DST) begin
            c_res = neg ? -$signed(dmag) : $signed(dmag);
            c_sat = (amag_q > SMAX_W);
        end else begin
            c_res = neg ? -$signed(WIDTH'(dgt)) : $signed(WIDTH'(dgt));
            c_sat = 1'b0;
        end

        s_res = (state_q == MUL) ? m_res : c_res;
        s_sat = (state_q == MUL) ? m_sat : c_sat;
    end

    logic                    ld;
    logic signed [WIDTH-1:0] res_d;
    logic                    sat_d;

    assign ld    = (accept && !is_mul && !is_conv)
                 || (((state_q == MUL) || (state_q == CONV)) && last);
    assign res_d = (state_q == IDLE) ? f_res : s_res;
    assign sat_d = (state_q == IDLE) ? f_sat : s_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            a1_q        <= '0;
            a2_q        <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q     <= inst;
                        a1_q     <= arg1;
                        a2_q     <= arg2;
                        acc_q    <= acc;
                        cnt_q    <= '0;
                        mcand_q  <= {{WIDTH{1'b0}}, acc_mag};
                        mplier_q <= mag(arg1);
                        prod_q   <= '0;
                        bin_q    <= acc_clip;
                        bcd_q    <= '0;
                        unique case (1'b1)
                            is_mul:  state_q <= MUL;
                            is_conv: state_q <= CONV;
                            default: begin
                                out_q       <= res_d;
                                out_valid_q <= 1'b1;
                                state_q     <= DONE;
                            end
                        endcase
                    end
                end
                MUL, CONV: begin
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    prod_q   <= pnx;
                    bin_q    <= bin_q << 1;
                    bcd_q    <= bcd_nx;
                    cnt_q    <= cnt_q + 1'b1;
                    if (last) begin
                        out_q       <= res_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic sat_q, zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (ld) begin
            sat_q  <= sat_d;
            zero_q <= (res_d == '0);
        end
    end

    assign out_sat  = sat_q;
    assign out_zero = zero_q;
`else
    logic unused_flags;
    assign unused_flags = sat_d ^ ld;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed vector bench for alu_seq: table of ops plus backpressure and reset sequences.
module tb_alu_seq;

    localparam int WIDTH = 11;
    localparam int LMUL  = WIDTH + 1;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [3:0]              inst;
    logic signed [WIDTH-1:0] arg1, arg2, acc;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out;
`ifdef ALU_SEQ_FLAGS_EN
    logic                    out_sat, out_zero;
`endif

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(WIDTH), .DIGITS(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst      (inst),
        .arg1      (arg1),
        .arg2      (arg2),
        .acc       (acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
`ifdef ALU_SEQ_FLAGS_EN
        ,
        .out_sat   (out_sat),
        .out_zero  (out_zero)
`endif
    );

    typedef struct {
        logic [3:0] inst;
        int         acc;
        int         a1;
        int         a2;
        int         exp;
        int         lat;
        bit         sat;
    } vec_t;

    vec_t vt[24];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int w;
        int lat;
        int busy_ready;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk($sformatf("v%0d in_ready", k), int'(in_ready), 1);
        inst     = v.inst;
        acc      = WIDTH'(v.acc);
        arg1     = WIDTH'(v.a1);
        arg2     = WIDTH'(v.a2);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        inst     = 4'd5;
        acc      = 11'sd321;
        arg1     = -11'sd77;
        arg2     = 11'sd4;
        lat        = 1;
        busy_ready = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_ready++;
            @(posedge clk);
            #1;
            lat++;
        end
        chk($sformatf("v%0d op%0d latency", k, v.inst), lat, v.lat);
        chk($sformatf("v%0d op%0d out", k, v.inst), int'(out), v.exp);
        chk($sformatf("v%0d busy in_ready", k), busy_ready + int'(in_ready), 0);
`ifdef ALU_SEQ_FLAGS_EN
        chk($sformatf("v%0d out_sat", k), int'(out_sat), int'(v.sat));
        chk($sformatf("v%0d out_zero", k), int'(out_zero), int'(v.exp == 0));
`endif
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk($sformatf("v%0d out_valid clr", k), int'(out_valid), 0);
        chk($sformatf("v%0d ready after", k), int'(in_ready), 1);
    endtask

    initial begin
        vt[0]  = '{4'd5,   400,   300, 0,   700,    1, 1'b0};
        vt[1]  = '{4'd5,   900,   500, 0,   999,    1, 1'b1};
        vt[2]  = '{4'd6,  -900,   500, 0,  -999,    1, 1'b1};
        vt[3]  = '{4'd6,   100,  -899, 0,   999,    1, 1'b0};
        vt[4]  = '{4'd5, -1024, -1024, 0,  -999,    1, 1'b1};
        vt[5]  = '{4'd7,   -12,    11, 0,  -132, LMUL, 1'b0};
        vt[6]  = '{4'd7,    40,    30, 0,   999, LMUL, 1'b1};
        vt[7]  = '{4'd7,   -37,    27, 0,  -999, LMUL, 1'b0};
        vt[8]  = '{4'd7,     0,    -5, 0,     0, LMUL, 1'b0};
        vt[9]  = '{4'd7, -1024, -1024, 0,   999, LMUL, 1'b1};
        vt[10] = '{4'd8,     0,     0, 0,   100,    1, 1'b0};
        vt[11] = '{4'd8,     5,     0, 0,     0,    1, 1'b0};
        vt[12] = '{4'd3, -1000,     0, 0, -1000,    1, 1'b0};
        vt[13] = '{4'd0,  1023,     0, 0,  1023,    1, 1'b0};
        vt[14] = '{4'd10, -472,     1, 0,    -7, LMUL, 1'b0};
        vt[15] = '{4'd10, -472,     3, 0,     0, LMUL, 1'b0};
        vt[16] = '{4'd10,  472,    -1, 0,     0, LMUL, 1'b0};
        vt[17] = '{4'd10, 1023,     2, 0,     9, LMUL, 1'b0};
        vt[18] = '{4'd10,  472,     0, 0,     2, LMUL, 1'b0};
        vt[19] = '{4'd11,  123,     2, 9,   923, LMUL, 1'b0};
        vt[20] = '{4'd11,  -45,     0, 15,  -49, LMUL, 1'b0};
        vt[21] = '{4'd11,    0,     1, 5,    50, LMUL, 1'b0};
        vt[22] = '{4'd11, -300,    -1, 3,  -300, LMUL, 1'b0};
        vt[23] = '{4'd11,   57,     0, -3,   50, LMUL, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        inst      = '0;
        acc       = '0;
        arg1      = '0;
        arg2      = '0;
        #1;
        chk("reset out", int'(out), 0);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset in_ready", int'(in_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // out_ready with nothing pending must be harmless
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle out_ready valid", int'(out_valid), 0);
        chk("idle out_ready ready", int'(in_ready), 1);

        for (int i = 0; i < 24; i++)
            run_vec(vt[i], i);

        // Backpressure: result held, new requests ignored.
        @(negedge clk);
        inst = 4'd5; acc = 11'sd1; arg1 = 11'sd2; in_valid = 1'b1;
        @(posedge clk);
        #1;
        acc = 11'sd100; arg1 = 11'sd100;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp%0d out", c), int'(out), 3);
            chk($sformatf("bp%0d out_valid", c), int'(out_valid), 1);
            chk($sformatf("bp%0d in_ready", c), int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp release valid", int'(out_valid), 0);
        chk("bp release ready", int'(in_ready), 1);
        repeat (3) @(negedge clk);
        chk("bp not queued", int'(out_valid), 0);

        // Reset in the middle of a multiply.
        @(negedge clk);
        inst = 4'd7; acc = -11'sd12; arg1 = 11'sd11; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst out_valid", int'(out_valid), 0);
        chk("mrst out", int'(out), 0);
        chk("mrst in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mrst rel ready", int'(in_ready), 1);
        repeat (15) @(negedge clk);
        chk("mrst no partial", int'(out_valid), 0);
        run_vec('{4'd5, 250, -50, 0, 200, 1, 1'b0}, 99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
